// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the execute-stage control unit and the ALU.
interface multicycle_alu_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (
      output in_valid, op, A, B,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  in_valid, op, A, B,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle integer ALU: single-cycle logic/add/sub/sltu plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_alu_if.slave       bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_REMU = 4'b1011;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       op_q;
   // MUL: acc = partial product, opa = shifted multiplicand, opb = shifted multiplier.
   // DIV: acc = partial remainder, opa = dividend shifting out / quotient shifting in,
   //      opb = divisor.
   logic [WIDTH-1:0] acc, opa, opb;
   logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx, fin;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] alu_res;
   logic             alu_legal, is_multi;

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign is_multi = (bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);

   // Single-cycle datapath, evaluated on the live request operands.
   always_comb begin
      alu_res   = '0;
      alu_legal = 1'b1;
      case (bus.op)
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_ADD:  alu_res = bus.A + bus.B;
         OP_SUB:  alu_res = bus.A - bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         default: alu_legal = 1'b0;
      endcase
   end

   // One multiply or divide iteration on the captured operands.
   always_comb begin
      acc_nx = acc;
      opa_nx = opa;
      opb_nx = opb;
      trial  = '0;
      if (op_q == OP_MUL) begin
         acc_nx = acc + (opb[0] ? opa : '0);
         opa_nx = opa << 1;
         opb_nx = opb >> 1;
      end else begin
         // W+1 bits is enough: the shifted remainder minus divisor lies in (-2^W, 2^W).
         trial = {acc, opa[WIDTH-1]} - {1'b0, opb};
         if (!trial[WIDTH]) acc_nx = trial[WIDTH-1:0];
         else               acc_nx = {acc[WIDTH-2:0], opa[WIDTH-1]};
         opa_nx = {opa[WIDTH-2:0], ~trial[WIDTH]};
      end
      // A zero divisor needs no special case: every trial succeeds, giving
      // an all-ones quotient and a remainder equal to the dividend.
      fin = ((op_q == OP_MUL) || (op_q == OP_REMU)) ? acc_nx : opa_nx;
   end

   // Control FSM, iteration registers and the held result/zero outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_q       <= '0;
         acc        <= '0;
         opa        <= '0;
         opb        <= '0;
         bus.result <= '0;
         bus.zero   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               op_q <= bus.op;
               if (is_multi) begin
                  state <= S_BUSY;
                  cnt   <= '0;
                  acc   <= '0;
                  opa   <= bus.A;
                  opb   <= bus.B;
               end else begin
                  state      <= S_DONE;
                  bus.result <= alu_res;
                  bus.zero   <= alu_legal && (alu_res == '0);
               end
            end
            S_BUSY: begin
               acc <= acc_nx;
               opa <= opa_nx;
               opb <= opb_nx;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state      <= S_DONE;
                  bus.result <= fin;
                  bus.zero   <= (fin == '0);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
